hilo_muldiv_unit: RTL
=====================

Name: hilo_muldiv_unit

Overview:
Parametrised multi-cycle multiply/divide unit that owns the architectural HI/LO pair. It executes MULT/MULTU/MADD/MADDU/MSUB/MSUBU/DIV/DIVU iteratively and MTHI/MTLO in one cycle, and exposes HI/LO continuously for MFHI/MFLO. It sits beside the ALU in EX. The pipeline issues ops with a Start/Busy/Done handshake and stalls on Busy.

Parameters:
DATA_WIDTH, 32, operand/HI/LO width; must be even and at least 4
EARLY_ZERO, 1, when 1 a multiply-class op with A==0 or B==0 completes on the fast path

Ports:
Clk  in  1  clock, all state updates on rising edge
Rst  in  1  asynchronous, active-high reset
Start  in  1  issue request; sampled only in IDLE
Op  in  4  0 MULT, 1 MULTU, 2 MADD, 3 MADDU, 4 MSUB, 5 MSUBU, 6 DIV, 7 DIVU, 8 MTHI, 9 MTLO, others reserved
A  in  DATA_WIDTH  rs operand (dividend for DIV*)
B  in  DATA_WIDTH  rt operand (divisor for DIV*)
Abort  in  1  pipeline flush; cancels any in-flight op
Busy  out  1  op in progress; pipeline must stall issue
Done  out  1  one-cycle pulse when HI/LO commit
DivByZero  out  1  one-cycle pulse with Done when DIV*/DIVU had B==0
Hi  out  DATA_WIDTH  architectural HI register
Lo  out  DATA_WIDTH  architectural LO register

Behaviour:
- Clock and reset: single clock Clk; Rst is asynchronous, active-high.
- Reset values: Hi=0, Lo=0, Busy=0, Done=0, DivByZero=0, state IDLE, counter 0.
- States: IDLE, RUN, FINISH.
- IDLE + Start + legal Op, Abort=0, edge k:
  - Op not reserved: latch A, B, Op, and a copy of Hi/Lo.
  - Signed ops: store |A|, |B| and the result sign.
  - Busy=1 after edge k.
- MTHI/MTLO:
  - Write A into Hi (or Lo) at edge k.
  - Done=1 for the cycle after edge k; Busy stays 0. No RUN.
- Multiply class:
  - RUN lasts DATA_WIDTH edges, one shift-add step per edge.
  - FINISH edge applies sign (2's complement negate of the 2*DATA_WIDTH product).
  - MADD*: add to latched {Hi,Lo}. MSUB*: subtract from it. Both mod 2^(2*DATA_WIDTH).
  - Commits Hi=upper half, Lo=lower half at edge k+DATA_WIDTH+1.
  - Done=1 and Busy=0 the following cycle.
- EARLY_ZERO=1 and A==0 or B==0:
  - Skip RUN; go to FINISH at edge k (product 0, accumulate still applied).
  - Commit at edge k+1.
- Divide class:
  - Restoring division, DATA_WIDTH RUN edges, same latency as multiply.
  - Quotient truncates toward zero and goes to Lo. Remainder takes the dividend's sign and goes to Hi.
  - Signed MIN / -1 yields Lo=MIN, Hi=0 (wraparound, no trap).
- B==0 on DIV/DIVU:
  - No RUN; Hi/Lo unchanged.
  - Done=1 and DivByZero=1 for the cycle after edge k.
- Busy stays high from edge k until the commit edge.
- Start while Busy is ignored.
- Reserved Op: Start ignored, no Done.
- Abort:
  - Any cycle with Abort=1 returns to IDLE at the next edge.
  - Hi/Lo keep their pre-op values, no Done.
  - Abort and Start in the same IDLE cycle: Abort wins, nothing issues.
  - Abort on the FINISH edge: commit suppressed.
- Rst asserted mid-operation: immediate return to reset values; no Done afterwards.
- Done and DivByZero are registered outputs (no combinational path from Start).
- Hi/Lo outputs are registers and change only on commit, MTHI/MTLO or Rst.
- Counter width: clog2(DATA_WIDTH+1).

Decomposition:
- Shared package (mips_pkg): Op encodings above, state enum {IDLE, RUN, FINISH}, DATA_WIDTH default.
- One sub-module, muldiv_step: combinational single-iteration datapath.
  - Multiply: conditional add plus shift of {acc, multiplier}.
  - Divide: trial subtract, restore, shift of {rem, quotient}.
  - Selected by a mode bit.
- Top level holds the FSM, counter, sign/accumulate fix-up and HI/LO registers.

Test Plan:
- MULT A=0xFFFFFFFD (-3), B=7 -> Hi=0xFFFFFFFF, Lo=0xFFFFFFEB; Done exactly 34 cycles after the Start edge; Busy high for 33 cycles.
- MULTU A=B=0xFFFFFFFF -> Hi=0xFFFFFFFE, Lo=0x00000001; then MULT with A=0 (EARLY_ZERO=1) -> Hi=Lo=0, Done after 2 cycles.
- MTHI 0, MTLO 0xFFFFFFFF, MADDU A=1 B=1 -> Hi=1, Lo=0; then MSUB A=1 B=1 -> Hi=0, Lo=0xFFFFFFFF.
- DIV A=0xFFFFFFF9 (-7), B=2 -> Lo=0xFFFFFFFD, Hi=0xFFFFFFFF; DIV 0x80000000 / 0xFFFFFFFF -> Lo=0x80000000, Hi=0.
- DIVU A=5, B=0 with Hi=0x11, Lo=0x22 -> Done and DivByZero pulse 1 cycle after Start; Hi=0x11, Lo=0x22 unchanged.
- Abort asserted 10 cycles into MULT -> Busy low next cycle, no Done, Hi/Lo unchanged; Start during Busy ignored; Rst mid-DIV -> Hi=Lo=0, Busy=0 immediately.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared definitions for the HI/LO multiply/divide unit: op encodings,
// FSM states and the default datapath width.
package mips_pkg;

   localparam int DATA_WIDTH_DEFAULT = 32;

   typedef enum logic [3:0] {
      OP_MULT  = 4'd0,
      OP_MULTU = 4'd1,
      OP_MADD  = 4'd2,
      OP_MADDU = 4'd3,
      OP_MSUB  = 4'd4,
      OP_MSUBU = 4'd5,
      OP_DIV   = 4'd6,
      OP_DIVU  = 4'd7,
      OP_MTHI  = 4'd8,
      OP_MTLO  = 4'd9
   } op_e;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      FINISH
   } state_e;

   function automatic logic op_is_signed(input op_e op);
      return (op == OP_MULT) || (op == OP_MADD) || (op == OP_MSUB) || (op == OP_DIV);
   endfunction

endpackage

// File: rtl/muldiv_step.sv
// One iteration of the shared shift-add multiplier / restoring divider.
// {hi, lo} holds {acc, multiplier} in multiply mode and {rem, quotient} in divide mode.
module muldiv_step #(
   parameter int DATA_WIDTH = 32
) (
   input  logic                  div_mode,
   input  logic [DATA_WIDTH-1:0] hi_in,
   input  logic [DATA_WIDTH-1:0] lo_in,
   input  logic [DATA_WIDTH-1:0] operand,
   output logic [DATA_WIDTH-1:0] hi_out,
   output logic [DATA_WIDTH-1:0] lo_out
);

   logic [DATA_WIDTH:0] sum;
   logic [DATA_WIDTH:0] shifted;
   logic [DATA_WIDTH:0] trial;

   always_comb begin
      sum     = {1'b0, hi_in} + (lo_in[0] ? {1'b0, operand} : '0);
      shifted = {hi_in, lo_in[DATA_WIDTH-1]};
      trial   = shifted - {1'b0, operand};
      hi_out  = '0;
      lo_out  = '0;
      if (!div_mode) begin
         {hi_out, lo_out} = {sum, lo_in[DATA_WIDTH-1:1]};
      end else if (!trial[DATA_WIDTH]) begin
         // Top bit clear means the trial subtract did not borrow
         hi_out = trial[DATA_WIDTH-1:0];
         lo_out = {lo_in[DATA_WIDTH-2:0], 1'b1};
      end else begin
         hi_out = shifted[DATA_WIDTH-1:0];
         lo_out = {lo_in[DATA_WIDTH-2:0], 1'b0};
      end
   end

endmodule

// File: rtl/hilo_muldiv_unit.sv
// Iterative multiply/divide unit owning the architectural HI/LO pair,
// issued through a Start/Busy/Done handshake from the EX stage.
module hilo_muldiv_unit
   import mips_pkg::*;
#(
   parameter int DATA_WIDTH = DATA_WIDTH_DEFAULT,
   parameter bit EARLY_ZERO = 1'b1
) (
   input  logic                  Clk,
   input  logic                  Rst,
   input  logic                  Start,
   input  logic [3:0]            Op,
   input  logic [DATA_WIDTH-1:0] A,
   input  logic [DATA_WIDTH-1:0] B,
   input  logic                  Abort,
   output logic                  Busy,
   output logic                  Done,
   output logic                  DivByZero,
   output logic [DATA_WIDTH-1:0] Hi,
   output logic [DATA_WIDTH-1:0] Lo
);

   localparam int CW = $clog2(DATA_WIDTH + 1);
   localparam logic [CW-1:0] LAST = CW'(DATA_WIDTH - 1);

   state_e                  state;
   op_e                     op_q;
   logic [CW-1:0]           cnt;
   logic [DATA_WIDTH-1:0]   work_hi;
   logic [DATA_WIDTH-1:0]   work_lo;
   logic [DATA_WIDTH-1:0]   operand_q;
   logic [2*DATA_WIDTH-1:0] acc_q;
   logic                    neg_res;
   logic                    neg_rem;

   op_e                     op_in;
   logic                    sgn_in;
   logic [DATA_WIDTH-1:0]   abs_a;
   logic [DATA_WIDTH-1:0]   abs_b;
   logic                    zero_fast;
   logic                    div_mode;
   logic [DATA_WIDTH-1:0]   step_hi;
   logic [DATA_WIDTH-1:0]   step_lo;
   logic [2*DATA_WIDTH-1:0] prod;
   logic [2*DATA_WIDTH-1:0] result;

   assign op_in     = op_e'(Op);
   assign sgn_in    = op_is_signed(op_in);
   assign abs_a     = (sgn_in && A[DATA_WIDTH-1]) ? -A : A;
   assign abs_b     = (sgn_in && B[DATA_WIDTH-1]) ? -B : B;
   assign zero_fast = EARLY_ZERO && ((A == '0) || (B == '0));
   assign div_mode  = (op_q == OP_DIV) || (op_q == OP_DIVU);

   muldiv_step #(.DATA_WIDTH(DATA_WIDTH)) u_step (
      .div_mode (div_mode),
      .hi_in    (work_hi),
      .lo_in    (work_lo),
      .operand  (operand_q),
      .hi_out   (step_hi),
      .lo_out   (step_lo)
   );

   // Sign and accumulate fix-up applied on the FINISH edge
   always_comb begin
      prod   = neg_res ? -{work_hi, work_lo} : {work_hi, work_lo};
      result = prod;
      case (op_q)
         OP_MADD, OP_MADDU: result = acc_q + prod;
         OP_MSUB, OP_MSUBU: result = acc_q - prod;
         OP_DIV, OP_DIVU:   result = {(neg_rem ? -work_hi : work_hi),
                                      (neg_res ? -work_lo : work_lo)};
         default:           result = prod;
      endcase
   end

   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) begin
         state     <= IDLE;
         op_q      <= OP_MULT;
         cnt       <= '0;
         work_hi   <= '0;
         work_lo   <= '0;
         operand_q <= '0;
         acc_q     <= '0;
         neg_res   <= 1'b0;
         neg_rem   <= 1'b0;
         Busy      <= 1'b0;
         Done      <= 1'b0;
         DivByZero <= 1'b0;
         Hi        <= '0;
         Lo        <= '0;
      end else begin
         Done      <= 1'b0;
         DivByZero <= 1'b0;
         if (Abort) begin
            state <= IDLE;
            cnt   <= '0;
            Busy  <= 1'b0;
         end else begin
            case (state)
               IDLE: begin
                  if (Start) begin
                     case (op_in)
                        OP_MTHI: begin
                           Hi   <= A;
                           Done <= 1'b1;
                        end
                        OP_MTLO: begin
                           Lo   <= A;
                           Done <= 1'b1;
                        end
                        OP_MULT, OP_MULTU, OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU: begin
                           op_q      <= op_in;
                           acc_q     <= {Hi, Lo};
                           work_hi   <= '0;
                           work_lo   <= zero_fast ? '0 : abs_b;
                           operand_q <= abs_a;
                           neg_res   <= sgn_in && (A[DATA_WIDTH-1] ^ B[DATA_WIDTH-1]);
                           neg_rem   <= 1'b0;
                           cnt       <= '0;
                           Busy      <= 1'b1;
                           state     <= zero_fast ? FINISH : RUN;
                        end
                        OP_DIV, OP_DIVU: begin
                           if (B == '0) begin
                              Done      <= 1'b1;
                              DivByZero <= 1'b1;
                           end else begin
                              op_q      <= op_in;
                              acc_q     <= {Hi, Lo};
                              work_hi   <= '0;
                              work_lo   <= abs_a;
                              operand_q <= abs_b;
                              neg_res   <= sgn_in && (A[DATA_WIDTH-1] ^ B[DATA_WIDTH-1]);
                              neg_rem   <= sgn_in && A[DATA_WIDTH-1];
                              cnt       <= '0;
                              Busy      <= 1'b1;
                              state     <= RUN;
                           end
                        end
                        default: ;
                     endcase
                  end
               end
               RUN: begin
                  work_hi <= step_hi;
                  work_lo <= step_lo;
                  if (cnt == LAST) begin
                     cnt   <= '0;
                     state <= FINISH;
                  end else begin
                     cnt <= cnt + 1'b1;
                  end
               end
               FINISH: begin
                  Hi    <= result[2*DATA_WIDTH-1:DATA_WIDTH];
                  Lo    <= result[DATA_WIDTH-1:0];
                  Done  <= 1'b1;
                  Busy  <= 1'b0;
                  state <= IDLE;
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

endmodule
